// File: rtl/ahb_bm_input_stage.sv
// Bus-matrix slave-port input stage: holds an address-phase transfer the
// target output stage cannot take yet, and stalls the master meanwhile.
module ahb_bm_input_stage #(
  parameter int ADDR_WIDTH   = 32,
  parameter int MASTER_WIDTH = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSELS,
  input  logic [ADDR_WIDTH-1:0]   HADDRS,
  input  logic [1:0]              HTRANSS,
  input  logic                    HWRITES,
  input  logic [2:0]              HSIZES,
  input  logic [2:0]              HBURSTS,
  input  logic [3:0]              HPROTS,
  input  logic [MASTER_WIDTH-1:0] HMASTERS,
  input  logic                    HMASTLOCKS,
  input  logic                    HREADYS,
  input  logic                    active_ip,
  input  logic                    readyout_ip,
  input  logic                    resp_ip,
  output logic                    HREADYOUTS,
  output logic                    HRESPS,
  output logic                    sel_ip,
  output logic [ADDR_WIDTH-1:0]   addr_ip,
  output logic [1:0]              trans_ip,
  output logic                    write_ip,
  output logic [2:0]              size_ip,
  output logic [2:0]              burst_ip,
  output logic [3:0]              prot_ip,
  output logic [MASTER_WIDTH-1:0] master_ip,
  output logic                    mastlock_ip,
  output logic                    held_tran_ip
);

  // state     | meaning
  // IDLE_PASS | nothing held, live inputs pass straight through
  // HOLD      | transfer captured, waiting for the output stage to accept it
  typedef enum logic {IDLE_PASS = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state;
  logic                    pend_tran;
  logic                    data_phase;
  logic                    new_tran;
  logic                    accept;
  logic                    capture;
  logic                    break_burst;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              trans_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [2:0]              burst_q;
  logic [3:0]              prot_q;
  logic [MASTER_WIDTH-1:0] master_q;
  logic                    mastlock_q;

  assign new_tran  = HSELS & HTRANSS[1] & HREADYS;
  assign accept    = active_ip & readyout_ip;
  assign pend_tran = (state == HOLD);
  assign capture   = ~pend_tran & new_tran & ~accept;
  // An ungranted SEQ beat may be re-arbitrated behind another master, so it
  // must restart as a fresh undefined-length burst.
  assign break_burst = (HTRANSS == 2'b11) & ~active_ip;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE_PASS;
      data_phase <= 1'b0;
      addr_q     <= '0;
      trans_q    <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      burst_q    <= '0;
      prot_q     <= '0;
      master_q   <= '0;
      mastlock_q <= 1'b0;
    end else begin
      case (state)
        IDLE_PASS: if (capture) state <= HOLD;
        HOLD:      if (accept)  state <= IDLE_PASS;
        default:   state <= IDLE_PASS;
      endcase

      if (capture) begin
        addr_q     <= HADDRS;
        trans_q    <= break_burst ? 2'b10  : HTRANSS;
        write_q    <= HWRITES;
        size_q     <= HSIZES;
        burst_q    <= break_burst ? 3'b001 : HBURSTS;
        prot_q     <= HPROTS;
        master_q   <= HMASTERS;
        mastlock_q <= HMASTLOCKS;
      end

      if ((new_tran | pend_tran) & accept)
        data_phase <= 1'b1;
      else if (readyout_ip)
        data_phase <= 1'b0;
    end
  end

  assign sel_ip       = pend_tran | HSELS;
  assign addr_ip      = pend_tran ? addr_q     : HADDRS;
  assign trans_ip     = pend_tran ? trans_q    : HTRANSS;
  assign write_ip     = pend_tran ? write_q    : HWRITES;
  assign size_ip      = pend_tran ? size_q     : HSIZES;
  assign burst_ip     = pend_tran ? burst_q    : HBURSTS;
  assign prot_ip      = pend_tran ? prot_q     : HPROTS;
  assign master_ip    = pend_tran ? master_q   : HMASTERS;
  assign mastlock_ip  = pend_tran ? mastlock_q : HMASTLOCKS;
  assign held_tran_ip = pend_tran | new_tran;

  assign HREADYOUTS = pend_tran ? 1'b0 : (data_phase ? readyout_ip : 1'b1);
  assign HRESPS     = data_phase ? resp_ip : 1'b0;

endmodule

// File: doc/ahb_bm_input_stage.md
Name: ahb_bm_input_stage

Overview:
- Per-master slave-port front end of the custom AHB bus matrix. It sits directly upstream of the decoder and the per-slave output stages.
- Captures an address-phase transfer from the master. If the targeted output stage cannot take it immediately, it holds the transfer and stalls the master.
- Presents the live or held transfer downstream with a held_tran qualifier, and generates the master-side HREADYOUTS/HRESPS.

Parameters:
ADDR_WIDTH, 32, width of HADDRS/addr_ip
MASTER_WIDTH, 4, width of HMASTERS/master_ip

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  async active-low reset
HSELS  input  1  master-side select
HADDRS  input  ADDR_WIDTH  address
HTRANSS  input  2  transfer type
HWRITES  input  1  direction
HSIZES  input  3  size
HBURSTS  input  3  burst
HPROTS  input  4  protection
HMASTERS  input  MASTER_WIDTH  master ID
HMASTLOCKS  input  1  lock
HREADYS  input  1  bus HREADY seen by master
active_ip  input  1  this port is granted by the target output stage (from decoder)
readyout_ip  input  1  HREADYMUX of target output stage, routed back by decoder
resp_ip  input  1  slave HRESP routed back by decoder
HREADYOUTS  output  1  ready to master
HRESPS  output  1  response to master
sel_ip, addr_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip  output  (widths as inputs)  transfer presented to decoder/output stages
held_tran_ip  output  1  a valid transfer (live or held) is being presented

Behaviour:
- Clock/reset: HCLK rising edge. HRESETn is asynchronous, active-low.
- Reset values:
  - pend_tran=0, data_phase=0, holding registers=0.
  - HREADYOUTS=1, HRESPS=0 (OKAY).
  - Outputs show live inputs; held_tran_ip follows its combinational definition.
- Definitions:
  - new_tran = HSELS & HTRANSS[1] & HREADYS
  - accept = active_ip & readyout_ip
- Pending state, two states IDLE_PASS / HOLD:
  - IDLE_PASS -> HOLD when new_tran & ~accept. All address/control inputs load into the holding registers.
  - HOLD -> IDLE_PASS when accept.
  - new_tran & accept in IDLE_PASS: no hold, zero added latency.
- Output mux:
  - pend_tran=1: the holding registers drive the outputs.
  - pend_tran=0: the live inputs drive the outputs.
  - sel_ip = pend_tran | HSELS.
- held_tran_ip = pend_tran | new_tran.
  - IDLE/BUSY transfers never assert held_tran_ip.
  - They still pass through on the live path for the output stage's lock tracking.
- Burst break:
  - Held SEQ transfer that was not granted when captured: trans_ip is presented as NONSEQ (2'b10) and burst_ip as INCR (3'b001).
  - Reason: re-arbitration may interleave another master.
  - Unchanged when the capture cycle already had active_ip=1.
- data_phase register:
  - Set on the edge where (new_tran | pend_tran) & accept.
  - Else cleared on the edge where readyout_ip=1.
  - Else held.
- Master-side response:
  - HREADYOUTS = pend_tran ? 0 : (data_phase ? readyout_ip : 1).
  - HRESPS = data_phase ? resp_ip : 0.
  - Two-cycle ERROR is passed through unchanged.
- Latency:
  - Accepted-immediately transfer: 0 extra cycles.
  - Held transfer: master stalled exactly until the cycle after accept, plus the slave's data-phase wait states.
- Simultaneous events:
  - new_tran cannot occur while pend_tran=1, because HREADYOUTS=0 forces HREADYS low.
  - If it is seen anyway, the holding registers are NOT overwritten; the held transfer has priority.
- Lock: mastlock_ip is held with the transfer; no lock arbitration is done here.
- Reset mid-operation: any held transfer is discarded, and HREADYOUTS returns to 1 asynchronously.

Test Plan:
- Reset asserted mid-HOLD -> HREADYOUTS=1, held_tran_ip=0, pend_tran=0 immediately; no transfer is re-presented after release.
- NONSEQ write to 0x2000_0000 with active_ip=1 and readyout_ip=1 -> same-cycle addr_ip=0x2000_0000, held_tran_ip=1, no hold.
  - Next cycle: data_phase=1; HREADYOUTS tracks readyout_ip (2 wait states -> 2 low cycles).
- NONSEQ read 0x4000_0010 with active_ip=0 for 3 cycles -> HREADYOUTS=0 for those cycles; addr_ip stays 0x4000_0010 while HADDRS changes.
  - On active_ip=1 & readyout_ip=1: pend_tran clears next edge, then the data phase completes.
- SEQ INCR4 beat held while not granted -> trans_ip=2'b10, burst_ip=3'b001 until accepted.
- Slave ERROR (resp_ip=1, readyout_ip=0 then 1) during data phase -> HRESPS=1 for both cycles; HREADYOUTS=0 then 1.
- IDLE with HSELS=1 -> held_tran_ip=0, trans_ip=2'b00, HREADYOUTS=1, no state change.
